// File: rtl/mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch and data access.
// Optional fetch anti-starvation counter enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int FAIR_LIMIT  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;   // 1 = data port owns the transaction
  logic        store_q, store_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        fetch_first;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);
  logic [3:0] fair_q, fair_d;

  assign fetch_first = (fair_q == FAIR_MAX);

  always_comb begin
    fair_d = fair_q;
    if (i_gnt)
      fair_d = 4'd0;
    else if (d_gnt)
      fair_d = i_req ? fair_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) fair_q <= 4'd0;
    else       fair_q <= fair_d;
  end
`else
  assign fetch_first = 1'b0;
`endif

  // Grants are combinational in IDLE; data wins unless the fairness limit forces a fetch.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (d_req && !(i_req && fetch_first)) d_gnt = 1'b1;
      else if (i_req)                       i_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = {d_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = d_wdata;
      mem_be    = d_we ? d_be : 4'b1111;
    end else if (i_gnt) begin
      mem_addr  = {i_addr[ADDR_W-1:2], 2'b00};
      mem_be    = 4'b1111;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    store_d   = store_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
          owner_d = d_gnt;
          store_d = d_gnt & d_we;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!owner_q)      i_rdata_d = mem_rdata;
          else if (!store_q) d_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      owner_q   <= 1'b0;
      store_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      store_q   <= store_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_rvalid = !reset && state_q == RESP && !owner_q;
  assign d_rvalid = !reset && state_q == RESP &&  owner_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = state_q != IDLE;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: responses are checked against expectations queued at grant time.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int FAIR = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_d_rdata = '0;

  mem_arbiter #(.ADDR_W(32), .MEM_LATENCY(LAT), .FAIR_LIMIT(FAIR)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory model: byte-enabled writes, reads returned LAT cycles after issue.
  logic [31:0] mem [0:255];
  logic [7:0]  pipe [0:15];

  always @(posedge clock) begin
    for (int i = 15; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_addr[9:2];
    if (reset) begin
      mem[0] <= 32'h11111111;
      mem[1] <= 32'h22222222;
      mem[4] <= 32'h00500093;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  assign mem_rdata = mem[pipe[LAT-1]];

  always @(negedge clock) begin
    exp_t e;
    if (i_rvalid && d_rvalid) begin
      total_cnt++;
      $display("FAIL rvalid_both: i_rvalid=%0b d_rvalid=%0b, required at most one", i_rvalid, d_rvalid);
    end else if (i_rvalid || d_rvalid) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rvalid: port=%0b with no pending transaction", d_rvalid);
      end else begin
        e = sb.pop_front();
        if (d_rvalid !== e.port || (d_rvalid ? d_rdata : i_rdata) !== e.data)
          $display("FAIL response: port=%0b data=%h, required port=%0b data=%h",
                   d_rvalid, d_rvalid ? d_rdata : i_rdata, e.port, e.data);
        else
          pass_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_cycles(input int n, output int i_rv_at, output int d_rv_at,
                            output int rv_cnt, output logic busy_last);
    i_rv_at = -1; d_rv_at = -1; rv_cnt = 0; busy_last = 1'bx;
    for (int k = 1; k <= n; k++) begin
      step();
      i_req = 1'b0;
      d_req = 1'b0;
      @(negedge clock);
      if (i_rvalid && i_rv_at < 0) i_rv_at = k;
      if (d_rvalid && d_rv_at < 0) d_rv_at = k;
      if (i_rvalid || d_rvalid) rv_cnt++;
      busy_last = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h44;
    step(); step();
    @(negedge clock);
    total_cnt++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || mem_be !== 4'h0)
      $display("FAIL reset_state: gnt=%b%b rv=%b%b en=%b we=%b busy=%b addr=%h be=%h, required all zero",
               i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy, mem_addr, mem_be);
    else pass_cnt++;
    step();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    exp_d_rdata = '0;
    step();
  endtask

  task automatic test_single_fetch();
    int ia, da, rc;
    logic bl;
    step();
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clock);
    total_cnt++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h10 ||
        mem_we !== 1'b0 || mem_be !== 4'hF)
      $display("FAIL fetch_issue: gnt=%b en=%b addr=%h we=%b be=%h, required 1 1 00000010 0 f",
               i_gnt, mem_en, mem_addr, mem_we, mem_be);
    else pass_cnt++;
    sb.push_back('{1'b0, 32'h00500093});
    run_cycles(LAT + 2, ia, da, rc, bl);
    total_cnt++;
    if (ia !== LAT + 1 || rc !== 1 || bl !== 1'b0)
      $display("FAIL fetch_timing: rvalid_at=%0d pulses=%0d busy=%b, required %0d 1 0", ia, rc, bl, LAT + 1);
    else pass_cnt++;
  endtask

  task automatic test_store_load();
    int ia, da, rc;
    logic bl;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h103; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    @(negedge clock);
    total_cnt++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 32'h100 || mem_we !== 1'b1 ||
        mem_be !== 4'hF || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL store_issue: gnt=%b addr=%h we=%b be=%h wdata=%h, required 1 00000100 1 f deadbeef",
               d_gnt, mem_addr, mem_we, mem_be, mem_wdata);
    else pass_cnt++;
    sb.push_back('{1'b1, exp_d_rdata});
    run_cycles(LAT + 2, ia, da, rc, bl);
    total_cnt++;
    if (da !== LAT + 1 || rc !== 1 || bl !== 1'b0)
      $display("FAIL store_timing: rvalid_at=%0d pulses=%0d busy=%b, required %0d 1 0", da, rc, bl, LAT + 1);
    else pass_cnt++;

    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678; d_be = 4'b0011;
    @(negedge clock);
    total_cnt++;
    if (mem_be !== 4'b0011 || mem_we !== 1'b1)
      $display("FAIL partial_store_be: be=%b we=%b, required 0011 1", mem_be, mem_we);
    else pass_cnt++;
    sb.push_back('{1'b1, exp_d_rdata});
    run_cycles(LAT + 2, ia, da, rc, bl);

    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'b0000;
    @(negedge clock);
    total_cnt++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 32'h100)
      $display("FAIL load_issue: gnt=%b we=%b be=%h addr=%h, required 1 0 f 00000100",
               d_gnt, mem_we, mem_be, mem_addr);
    else pass_cnt++;
    exp_d_rdata = 32'hDEAD5678;
    sb.push_back('{1'b1, exp_d_rdata});
    run_cycles(LAT + 4, ia, da, rc, bl);
    total_cnt++;
    if (d_rdata !== 32'hDEAD5678)
      $display("FAIL load_hold: d_rdata=%h, required dead5678", d_rdata);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int ig_at = -1;
    int extra_d = 0;
    logic got = 1'b0;
    step();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clock);
    total_cnt++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0)
      $display("FAIL priority: d_gnt=%b i_gnt=%b, required 1 0", d_gnt, i_gnt);
    else pass_cnt++;
    sb.push_back('{1'b1, exp_d_rdata});
    for (int k = 1; k <= 2 * LAT + 6; k++) begin
      step();
      d_req = 1'b0;
      if (got) i_req = 1'b0;
      @(negedge clock);
      if (d_gnt) extra_d++;
      if (i_gnt && ig_at < 0) begin
        ig_at = k;
        got = 1'b1;
        sb.push_back('{1'b0, 32'h00500093});
      end
    end
    total_cnt++;
    if (ig_at !== LAT + 2 || extra_d !== 0)
      $display("FAIL deferred_fetch: i_gnt_at=%0d extra_d_gnt=%0d, required %0d 0", ig_at, extra_d, LAT + 2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ia, da, rc;
    logic bl;
    step();
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clock);
    total_cnt++;
    if (i_gnt !== 1'b1)
      $display("FAIL reset_mid_grant: i_gnt=%b, required 1", i_gnt);
    else pass_cnt++;
    step();
    i_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    step();
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_be !== 4'h0)
      $display("FAIL reset_mid_state: rv=%b%b en=%b busy=%b i_rdata=%h d_rdata=%h, required all zero",
               i_rvalid, d_rvalid, mem_en, busy, i_rdata, d_rdata);
    else pass_cnt++;
    exp_d_rdata = '0;
    run_cycles(LAT + 3, ia, da, rc, bl);
    total_cnt++;
    if (rc !== 0)
      $display("FAIL reset_mid_rvalid: pulses=%0d, required 0", rc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int g2 = -1, rv1 = -1, rv2 = -1;
    logic seen2 = 1'b0;
    step();
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clock);
    total_cnt++;
    if (i_gnt !== 1'b1 || mem_addr !== 32'h0)
      $display("FAIL b2b_first: i_gnt=%b addr=%h, required 1 00000000", i_gnt, mem_addr);
    else pass_cnt++;
    sb.push_back('{1'b0, 32'h11111111});
    for (int k = 1; k <= 2 * LAT + 5; k++) begin
      step();
      if (k == 1) i_addr = 32'h4;
      if (seen2) i_req = 1'b0;
      @(negedge clock);
      if (i_gnt && !seen2) begin
        g2 = k;
        seen2 = 1'b1;
        sb.push_back('{1'b0, 32'h22222222});
      end
      if (i_rvalid) begin
        if (rv1 < 0) rv1 = k;
        else if (rv2 < 0) rv2 = k;
      end
    end
    total_cnt++;
    if (g2 !== LAT + 2 || rv1 !== LAT + 1 || rv2 !== 2 * LAT + 3)
      $display("FAIL b2b_timing: gnt2=%0d rv1=%0d rv2=%0d, required %0d %0d %0d",
               g2, rv1, rv2, LAT + 2, LAT + 1, 2 * LAT + 3);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    int   ng = 0;
    logic order [0:9];
    logic want;
    int   ia, da, rc;
    logic bl;
    step();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int k = 0; k < 10 * (LAT + 2) + 10 && ng < 10; k++) begin
      if (k > 0) step();
      @(negedge clock);
      if (i_gnt || d_gnt) begin
        order[ng] = d_gnt;
        ng++;
        if (d_gnt) exp_d_rdata = 32'h00500093;
        sb.push_back('{d_gnt, 32'h00500093});
      end
    end
    total_cnt++;
    if (ng !== 10)
      $display("FAIL fair_grant_count: grants=%0d, required 10", ng);
    else pass_cnt++;
    for (int n = 0; n < ng; n++) begin
`ifdef MEM_ARB_FAIR_EN
      want = (n % (FAIR + 1) == FAIR) ? 1'b0 : 1'b1;
`else
      want = 1'b1;
`endif
      total_cnt++;
      if (order[n] !== want)
        $display("FAIL fair_order_%0d: got %s, required %s", n, order[n] ? "D" : "I", want ? "D" : "I");
      else pass_cnt++;
    end
    run_cycles(LAT + 3, ia, da, rc, bl);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_fairness();
    step();
    @(negedge clock);
    total_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d responses missing, required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
